// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared constants and sequencer state type for the nibble-serial ALU
package ula_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ula_74181.sv
// rtl/ula_74181.sv - one 4-bit 74181 ALU slice, active-high data, active-low carry in/out
module ula_74181
  import ula_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic [3:0]          s,
  input  logic                m,
  input  logic                c_n,
  output logic [NIBBLE_W-1:0] f,
  output logic                c_n4,
  output logic                a_eq_b
);

  logic [NIBBLE_W-1:0] t1;
  logic [NIBBLE_W-1:0] t2;
  logic [NIBBLE_W:0]   sum;

  // Arithmetic mode adds the two select-shaped terms; logic mode is the carry-free XNOR of them.
  assign t1     = a | (b & {NIBBLE_W{s[0]}}) | (~b & {NIBBLE_W{s[1]}});
  assign t2     = (a & b & {NIBBLE_W{s[3]}}) | (a & ~b & {NIBBLE_W{s[2]}});
  assign sum    = {1'b0, t1} + {1'b0, t2} + {{NIBBLE_W{1'b0}}, ~c_n};
  assign f      = m ? ~(t1 ^ t2) : sum[NIBBLE_W-1:0];
  assign c_n4   = ~sum[NIBBLE_W];
  assign a_eq_b = &f;

endmodule

// File: rtl/ula_nibble_seq.sv
// rtl/ula_nibble_seq.sv - runs one NIBBLES-wide 74181 operation through a single slice, LSB nibble first
module ula_nibble_seq
  import ula_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic [3:0]                  s,
  input  logic                        m,
  input  logic                        c_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] f,
  output logic                        c_out,
  output logic                        a_eq_b,
  output logic                        zero
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;

  logic [NIBBLE_W-1:0] alu_f;
  logic                alu_c;
  logic                alu_eq;

  // Operands shift right so the active nibble is always at the bottom; the result fills from the top.
  ula_74181 u_alu (
    .a      (a_q[NIBBLE_W-1:0]),
    .b      (b_q[NIBBLE_W-1:0]),
    .s      (s_q),
    .m      (m_q),
    .c_n    (carry_q),
    .f      (alu_f),
    .c_n4   (alu_c),
    .a_eq_b (alu_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    f         = res_q;
    c_out     = m_q ? 1'b0 : carry_q;
    a_eq_b    = eq_q;
    zero      = (state_q == DONE) && (res_q == '0);
  end

  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    m_d     = m_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    if (state_q == IDLE && in_valid) begin
      idx_d   = '0;
      a_d     = a;
      b_d     = b;
      s_d     = s;
      m_d     = m;
      carry_d = c_in;
      eq_d    = 1'b1;
    end else if (state_q == RUN) begin
      idx_d   = idx_q + CNT_W'(1);
      a_d     = a_q >> NIBBLE_W;
      b_d     = b_q >> NIBBLE_W;
      res_d   = {alu_f, res_q[W-1:NIBBLE_W]};
      carry_d = alu_c;
      eq_d    = eq_q & alu_eq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
    end
  end

endmodule
